// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin arbiter and byte-lane controller for a single-port,
// byte-addressable data memory. Port 0 is the CPU load/store path, port 1
// is the loader/debug/DMA path. One access is serviced every two cycles:
// an IDLE cycle that grants a request, then an ACCESS cycle that drives
// the memory. The response is registered and appears in the following cycle.
module dmem_port_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic              req_we0,
  input  logic              req_we1,
  input  logic [1:0]        req_size0,
  input  logic [1:0]        req_size1,
  input  logic              req_unsigned0,
  input  logic              req_unsigned1,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [31:0]       req_wdata0,
  input  logic [31:0]       req_wdata1,
  output logic [1:0]        resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_we,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_t state;
  state_t state_next;

  // last_grant resets to 1 so that port 0 wins the first contested cycle
  logic last_grant;
  logic grant_any;
  logic grant_id;

  logic              lat_we;
  logic [1:0]        lat_size;
  logic              lat_unsigned;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic              lat_id;

  logic        acc_err;
  logic [3:0]  lane_we;
  logic [31:0] lane_wdata;
  logic [31:0] load_shift;
  logic [31:0] load_result;

  // Round-robin winner selection: a lone requester wins, a tie goes to
  // the port that was not granted last
  always_comb begin
    grant_any = |req_valid;
    grant_id  = 1'b0;
    if (req_valid == 2'b11) begin
      grant_id = ~last_grant;
    end else if (req_valid == 2'b10) begin
      grant_id = 1'b1;
    end
  end

  // Next-state and handshake: grant only in IDLE, ACCESS always lasts one cycle
  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    case (state)
      IDLE: begin
        if (grant_any) begin
          req_ready  = grant_id ? 2'b10 : 2'b01;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register and round-robin history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      if (state == IDLE && grant_any) begin
        last_grant <= grant_id;
      end
    end
  end

  // Capture the winning request so the requester may drop its fields after acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we       <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= 32'h0;
      lat_id       <= 1'b0;
    end else if (state == IDLE && grant_any) begin
      lat_id <= grant_id;
      if (grant_id) begin
        lat_we       <= req_we1;
        lat_size     <= req_size1;
        lat_unsigned <= req_unsigned1;
        lat_addr     <= req_addr1;
        lat_wdata    <= req_wdata1;
      end else begin
        lat_we       <= req_we0;
        lat_size     <= req_size0;
        lat_unsigned <= req_unsigned0;
        lat_addr     <= req_addr0;
        lat_wdata    <= req_wdata0;
      end
    end
  end

  // Alignment check and store lane generation from the latched request
  always_comb begin
    acc_err    = 1'b0;
    lane_we    = 4'b0000;
    lane_wdata = lat_wdata;
    case (lat_size)
      SIZE_BYTE: begin
        lane_we    = 4'b0001 << lat_addr[1:0];
        lane_wdata = {4{lat_wdata[7:0]}};
      end
      SIZE_HALF: begin
        acc_err    = lat_addr[0];
        lane_we    = lat_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{lat_wdata[15:0]}};
      end
      SIZE_WORD: begin
        acc_err    = (lat_addr[1:0] != 2'b00);
        lane_we    = 4'b1111;
        lane_wdata = lat_wdata;
      end
      default: begin
        acc_err = 1'b1;
      end
    endcase
  end

  // Memory drive: write enables only during a legal store in ACCESS, so a
  // reset mid-access drops them as soon as the state register clears
  always_comb begin
    mem_addr  = {lat_addr[ADDR_W-1:2], 2'b00};
    mem_wdata = lane_wdata;
    mem_we    = 4'b0000;
    if (state == ACCESS && lat_we && !acc_err) begin
      mem_we = lane_we;
    end
  end

  // Load extraction: shift the addressed lane down, then sign or zero extend
  always_comb begin
    load_shift  = mem_rdata >> {lat_addr[1:0], 3'b000};
    load_result = mem_rdata;
    case (lat_size)
      SIZE_BYTE: begin
        load_result = {{24{load_shift[7] & ~lat_unsigned}}, load_shift[7:0]};
      end
      SIZE_HALF: begin
        load_result = {{16{load_shift[15] & ~lat_unsigned}}, load_shift[15:0]};
      end
      default: begin
        load_result = mem_rdata;
      end
    endcase
  end

  // Registered response: one-cycle pulse after ACCESS, data held until the next response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 2'b00;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
    end else if (state == ACCESS) begin
      resp_valid <= lat_id ? 2'b10 : 2'b01;
      resp_err   <= acc_err;
      resp_rdata <= (acc_err || lat_we) ? 32'h0 : load_result;
    end else begin
      resp_valid <= 2'b00;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a byte-lane
// memory model behind the memory port.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic        req_we0, req_we1;
  logic [1:0]  req_size0, req_size1;
  logic        req_unsigned0, req_unsigned1;
  logic [31:0] req_addr0, req_addr1;
  logic [31:0] req_wdata0, req_wdata1;
  logic [1:0]  resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] tb_mem [0:255];

  int compared;
  int mismatched;

  dmem_port_arbiter #(.ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we0       (req_we0),
    .req_we1       (req_we1),
    .req_size0     (req_size0),
    .req_size1     (req_size1),
    .req_unsigned0 (req_unsigned0),
    .req_unsigned1 (req_unsigned1),
    .req_addr0     (req_addr0),
    .req_addr1     (req_addr1),
    .req_wdata0    (req_wdata0),
    .req_wdata1    (req_wdata1),
    .resp_valid    (resp_valid),
    .resp_err      (resp_err),
    .resp_rdata    (resp_rdata),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_rdata     (mem_rdata)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte-lane memory model with combinational read
  assign mem_rdata = tb_mem[mem_addr[9:2]];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we[b]) tb_mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic setPort(input int port, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      req_we0 = we; req_size0 = size; req_unsigned0 = uns;
      req_addr0 = addr; req_wdata0 = wdata;
    end else begin
      req_we1 = we; req_size1 = size; req_unsigned1 = uns;
      req_addr1 = addr; req_wdata1 = wdata;
    end
  endtask

  // One complete transaction on one port with checks on the memory side
  // during ACCESS and on the response in the cycle after
  task automatic applyStimulus(input string tag, input int port, input logic we,
                               input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] exp_we, input logic [31:0] exp_wdata,
                               input logic exp_err, input logic [31:0] exp_rdata);
    int n;
    @(negedge clk);
    setPort(port, we, size, uns, addr, wdata);
    req_valid[port] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[port] && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready[port]) begin
      checkOutput({tag, ".timeout"}, 32'd0, 32'd1);
      req_valid[port] = 1'b0;
      return;
    end
    checkOutput({tag, ".ready"}, {30'd0, req_ready}, (port == 0) ? 32'd1 : 32'd2);
    @(posedge clk);
    #1;
    req_valid[port] = 1'b0;
    checkOutput({tag, ".mem_we"}, {28'd0, mem_we}, {28'd0, exp_we});
    checkOutput({tag, ".mem_addr"}, mem_addr, {addr[31:2], 2'b00});
    if (exp_we != 4'b0000) checkOutput({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
    @(posedge clk);
    #1;
    checkOutput({tag, ".resp_valid"}, {30'd0, resp_valid}, (port == 0) ? 32'd1 : 32'd2);
    checkOutput({tag, ".resp_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    checkOutput({tag, ".resp_rdata"}, resp_rdata, exp_rdata);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    req_valid  = 2'b00;
    setPort(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    setPort(1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    #12;
    checkOutput("rst.req_ready", {30'd0, req_ready}, 32'd0);
    checkOutput("rst.resp_valid", {30'd0, resp_valid}, 32'd0);
    checkOutput("rst.resp_err", {31'd0, resp_err}, 32'd0);
    checkOutput("rst.resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst.mem_addr", mem_addr, 32'd0);
    checkOutput("rst.mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst.mem_we", {28'd0, mem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Word store then load
    applyStimulus("st_word", 0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0);
    applyStimulus("ld_word", 0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 4'b0000, 32'h0, 1'b0, 32'hDEADBEEF);
    // Byte store into lane 3, then signed and unsigned loads (word becomes 0x80ADBEEF)
    applyStimulus("st_byte", 0, 1'b1, 2'b00, 1'b0, 32'h103, 32'h00000080, 4'b1000, 32'h80808080, 1'b0, 32'h0);
    applyStimulus("ld_byte_s", 0, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 4'b0000, 32'h0, 1'b0, 32'hFFFFFF80);
    applyStimulus("ld_byte_u", 0, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 4'b0000, 32'h0, 1'b0, 32'h00000080);
    // Half store into upper half (word becomes 0xA55ABEEF), then loads
    applyStimulus("st_half", 0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000A55A, 4'b1100, 32'hA55AA55A, 1'b0, 32'h0);
    applyStimulus("ld_half_s", 0, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 4'b0000, 32'h0, 1'b0, 32'hFFFFA55A);
    applyStimulus("ld_half_u", 0, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 4'b0000, 32'h0, 1'b0, 32'h0000A55A);
    // Misaligned and illegal accesses leave memory untouched
    applyStimulus("st_misal", 0, 1'b1, 2'b10, 1'b0, 32'h101, 32'h11223344, 4'b0000, 32'h0, 1'b1, 32'h0);
    checkOutput("st_misal.mem", tb_mem[8'h40], 32'hA55ABEEF);
    applyStimulus("ld_half_misal", 0, 1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 4'b0000, 32'h0, 1'b1, 32'h0);
    applyStimulus("st_illegal", 0, 1'b1, 2'b11, 1'b0, 32'h100, 32'h55555555, 4'b0000, 32'h0, 1'b1, 32'h0);
    checkOutput("st_illegal.mem", tb_mem[8'h40], 32'hA55ABEEF);
    // Port 1 load of the low half, zero-extended
    applyStimulus("p1_ld_half_u", 1, 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 4'b0000, 32'h0, 1'b0, 32'h0000BEEF);
    // Port 1 byte store into lane 0, then port 0 reads it back signed
    applyStimulus("p1_st_byte", 1, 1'b1, 2'b00, 1'b0, 32'h104, 32'h000000C3, 4'b0001, 32'hC3C3C3C3, 1'b0, 32'h0);
    applyStimulus("ld_byte_104", 0, 1'b0, 2'b00, 1'b0, 32'h104, 32'h0, 4'b0000, 32'h0, 1'b0, {24'hFFFFFF, 8'hC3} & {24'hFFFFFF, tb_mem[8'h41][7:0]});

    // Arbitration: both ports valid from reset, grants alternate starting at port 0
    @(negedge clk);
    rst = 1'b1;
    setPort(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    setPort(1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    req_valid = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      logic [1:0] exp_ready;
      logic [1:0] exp_resp;
      exp_ready = 2'b00;
      exp_resp  = 2'b00;
      if (k % 2 == 0) exp_ready = ((k / 2) % 2 == 0) ? 2'b01 : 2'b10;
      if (k % 2 == 0 && k >= 2) exp_resp = (((k - 2) / 2) % 2 == 0) ? 2'b01 : 2'b10;
      checkOutput($sformatf("arb.ready%0d", k), {30'd0, req_ready}, {30'd0, exp_ready});
      checkOutput($sformatf("arb.resp%0d", k), {30'd0, resp_valid}, {30'd0, exp_resp});
      @(negedge clk);
      #1;
    end
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

    // Reset during the ACCESS of a store: write enables drop at once, no response
    setPort(1, 1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678);
    req_valid = 2'b10;
    #1;
    checkOutput("rstmid.ready", {30'd0, req_ready}, 32'd2);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    checkOutput("rstmid.we_access", {28'd0, mem_we}, 32'hF);
    rst = 1'b1;
    #1;
    checkOutput("rstmid.we_drop", {28'd0, mem_we}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rstmid.resp_valid", {30'd0, resp_valid}, 32'd0);
    checkOutput("rstmid.mem", tb_mem[8'h40], 32'hA55ABEEF);
    @(negedge clk);
    setPort(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    setPort(1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    req_valid = 2'b11;
    rst = 1'b0;
    #1;
    checkOutput("rstmid.first_grant", {30'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global watchdog so the bench always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Two-requester arbiter and load/store lane controller in front of the byte-addressable, single-port data memory.
- Port 0 is the CPU load/store path; port 1 is the loader/debug/DMA path.
- Grants one access at a time using round-robin, and generates the memory byte-lane write enables and replicated write data.
- Extracts and sign- or zero-extends load data, and rejects misaligned or illegal accesses.

Parameters:
- ADDR_W, 32, byte-address width on all ports.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-port request valid; bit n belongs to port n.
- req_ready  out  2  per-port request accepted; one-hot or zero.
- req_we0 / req_we1  in  1  per-port access type: 1 = store, 0 = load.
- req_size0 / req_size1  in  2  per-port size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned0 / req_unsigned1  in  1  per-port load extension: 1 = zero-extend, 0 = sign-extend.
- req_addr0 / req_addr1  in  ADDR_W  per-port byte address.
- req_wdata0 / req_wdata1  in  32  per-port store data, right-aligned.
- resp_valid  out  2  per-port response pulse, 1 cycle.
- resp_err  out  1  response is for a misaligned or illegal access.
- resp_rdata  out  32  load result; 0 for stores and for errors.
- mem_addr  out  ADDR_W  word-aligned address to memory (low 2 bits = 00).
- mem_wdata  out  32  lane-replicated store data.
- mem_we  out  4  byte-lane write enables.
- mem_rdata  in  32  combinational read data from memory.

Behaviour:
- Reset values (asynchronous, take effect immediately):
  - state = IDLE, last_grant = 1.
  - req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wdata, mem_we all 0.
- FSM has two states, IDLE and ACCESS.
- IDLE:
  - If any req_valid is high, pick a winner and assert req_ready for the winner only, combinationally in the same cycle.
  - Latch the winner's we/size/unsigned/addr/wdata and the port id, set last_grant = winner, and go to ACCESS.
  - mem_we = 0 while in IDLE.
- Arbitration:
  - Exactly one valid: that port wins.
  - Both valid: the port != last_grant wins.
  - After reset, port 0 wins the first contested cycle.
- ACCESS (exactly one cycle, then always back to IDLE):
  - Drive mem_addr = latched addr with bits [1:0] = 00.
  - Drive mem_we and mem_wdata from the latched request.
  - Sample mem_rdata at the clock edge that ends ACCESS.
- Response timing:
  - resp_valid[id] is registered; it is high for exactly the one cycle after ACCESS.
  - That cycle is IDLE, so a new grant may occur in it.
  - Throughput is 1 access per 2 cycles; request-to-response latency is 2 edges after acceptance.
- Alignment check, evaluated on latched values:
  - Error when size = 11, or half with addr[0] = 1, or word with addr[1:0] != 00.
  - On error: mem_we = 0 in ACCESS (memory untouched), resp_err = 1, resp_rdata = 0.
- Stores:
  - Byte: mem_wdata = {4{wdata[7:0]}}, mem_we = 0001 << addr[1:0].
  - Half: mem_wdata = {2{wdata[15:0]}}, mem_we = 0011 if addr[1] = 0, else 1100.
  - Word: mem_wdata = wdata, mem_we = 1111.
  - The response is an ack only: resp_err = 0, resp_rdata = 0.
- Loads:
  - Compute sh = mem_rdata >> (8 * addr[1:0]).
  - Byte result: sh[7:0] extended to 32 bits.
  - Half result: sh[15:0] extended to 32 bits.
  - Word result: mem_rdata.
  - Extension is zero-fill if unsigned = 1, else replicate the top bit of the field.
- resp_err and resp_rdata are held until the next response; they are meaningful only while resp_valid is high.
- Handshake:
  - A requester holds valid and all fields stable until it sees req_ready.
  - A requester may deassert valid after acceptance.
  - A port that is not granted keeps waiting; there is no timeout.
- Reset asserted during ACCESS:
  - Transaction aborted; no response issued.
  - mem_we drops to 0 asynchronously.

Test Plan:
- Word store then load: port 0 stores 0xDEADBEEF at 0x100, then loads word at 0x100 → mem_we = 1111, mem_addr = 0x100, resp_rdata = 0xDEADBEEF, resp_err = 0.
- Byte store and loads: store byte 0x80 at 0x103 → mem_we = 1000, mem_wdata = 0x80808080. Then load byte at 0x103 → signed gives 0xFFFFFF80, unsigned gives 0x00000080.
- Half store and loads: store half 0xA55A at 0x102 → mem_we = 1100. Then load half at 0x102 → signed gives 0xFFFFA55A, unsigned gives 0x0000A55A.
- Misaligned access: word store at 0x101 → mem_we stays 0000, resp_err = 1, resp_rdata = 0, and the memory word at 0x100 is unchanged.
- Arbitration: both ports hold valid continuously from reset → grants alternate 0, 1, 0, 1. One resp_valid pulse every 2 cycles on alternating bits; req_ready is never 2'b11.
- Reset mid-access: assert rst during the ACCESS of a store → mem_we goes to 0 immediately, no resp_valid, memory unchanged. After release, the first contested grant goes to port 0.
